// File: rtl/mouse_cursor_tracker.sv
// Turns the PS/2 mouse core's wrapping counters into a screen-clamped cursor, a saturating wheel and button events.
// Build option: define MOUSE_ACCEL_EN to double X/Y deltas whose magnitude reaches ACCEL_THRESH.
module mouse_cursor_tracker #(
    parameter int unsigned C_BITS       = 11,
    parameter int unsigned SCREEN_W     = 640,
    parameter int unsigned SCREEN_H     = 480,
    parameter int unsigned INVERT_Y     = 1,
    parameter int unsigned ACCEL_THRESH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [C_BITS-1:0] mouse_x,
    input  logic [C_BITS-1:0] mouse_y,
    input  logic [C_BITS-1:0] mouse_z,
    input  logic [2:0]        mouse_btn,
    input  logic              center,
    output logic [10:0]       cursor_x,
    output logic [10:0]       cursor_y,
    output logic [7:0]        wheel_pos,
    output logic [2:0]        btn_down,
    output logic [2:0]        btn_press,
    output logic [2:0]        btn_release,
    output logic              update
);

    localparam int unsigned ACC_W = C_BITS + 2;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_TRACK = 1'b1;

`ifdef MOUSE_ACCEL_EN
    localparam logic ACCEL_EN = 1'b1;
`else
    localparam logic ACCEL_EN = 1'b0;
`endif

    localparam logic [10:0]             CX_HOME   = 11'(SCREEN_W / 2);
    localparam logic [10:0]             CY_HOME   = 11'(SCREEN_H / 2);
    localparam logic signed [ACC_W-1:0] X_MAX     = ACC_W'(SCREEN_W - 1);
    localparam logic signed [ACC_W-1:0] Y_MAX     = ACC_W'(SCREEN_H - 1);
    localparam logic signed [ACC_W-1:0] W_MIN     = ACC_W'(-128);
    localparam logic signed [ACC_W-1:0] W_MAX     = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] ACCEL_LIM = ACC_W'(ACCEL_THRESH);

    // Counter differences are taken modulo 2^C_BITS and read as signed.
    function automatic logic signed [ACC_W-1:0] sext_delta(input logic [C_BITS-1:0] d);
        return {{2{d[C_BITS-1]}}, d};
    endfunction

    function automatic logic signed [ACC_W-1:0] scale_delta(input logic [C_BITS-1:0] d);
        logic signed [ACC_W-1:0] v;
        logic signed [ACC_W-1:0] mag;
        v   = sext_delta(d);
        mag = v[ACC_W-1] ? -v : v;
        if (ACCEL_EN && (mag >= ACCEL_LIM)) begin
            v = v <<< 1;
        end
        return v;
    endfunction

    function automatic logic [10:0] clamp_axis(input logic signed [ACC_W-1:0] v,
                                               input logic signed [ACC_W-1:0] vmax);
        if (v[ACC_W-1]) begin
            return 11'd0;
        end
        if (v > vmax) begin
            return 11'(vmax);
        end
        return 11'(v);
    endfunction

    logic [0:0]        state_q, state_d;
    logic [C_BITS-1:0] prev_x_q, prev_x_d;
    logic [C_BITS-1:0] prev_y_q, prev_y_d;
    logic [C_BITS-1:0] prev_z_q, prev_z_d;
    logic [2:0]        prev_btn_q, prev_btn_d;

    logic              s1_valid_q, s1_valid_d;
    logic [C_BITS-1:0] s1_dx_q, s1_dx_d;
    logic [C_BITS-1:0] s1_dy_q, s1_dy_d;
    logic [C_BITS-1:0] s1_dz_q, s1_dz_d;
    logic [2:0]        s1_btn_q, s1_btn_d;
    logic [2:0]        s1_press_q, s1_press_d;
    logic [2:0]        s1_rel_q, s1_rel_d;
    logic              s1_center_q, s1_center_d;

    logic [10:0]       cursor_x_q, cursor_x_d;
    logic [10:0]       cursor_y_q, cursor_y_d;
    logic signed [7:0] wheel_q, wheel_d;
    logic [2:0]        btn_down_q, btn_down_d;
    logic [2:0]        btn_press_q, btn_press_d;
    logic [2:0]        btn_release_q, btn_release_d;
    logic              update_q, update_d;

    logic signed [ACC_W-1:0] sum_x;
    logic signed [ACC_W-1:0] sum_y;
    logic signed [ACC_W-1:0] sum_w;
    logic [10:0]             nx;
    logic [10:0]             ny;
    logic signed [7:0]       nw;

    // FSM and stage 1: baseline capture, then per-cycle deltas and button edges.
    always_comb begin
        state_d     = state_q;
        prev_x_d    = mouse_x;
        prev_y_d    = mouse_y;
        prev_z_d    = mouse_z;
        prev_btn_d  = mouse_btn;
        s1_valid_d  = 1'b0;
        s1_dx_d     = '0;
        s1_dy_d     = '0;
        s1_dz_d     = '0;
        s1_btn_d    = '0;
        s1_press_d  = '0;
        s1_rel_d    = '0;
        s1_center_d = 1'b0;
        case (state_q)
            ST_INIT: begin
                state_d = ST_TRACK;
            end
            ST_TRACK: begin
                s1_valid_d  = 1'b1;
                s1_dx_d     = mouse_x - prev_x_q;
                s1_dy_d     = mouse_y - prev_y_q;
                s1_dz_d     = mouse_z - prev_z_q;
                s1_btn_d    = mouse_btn;
                s1_press_d  = mouse_btn & ~prev_btn_q;
                s1_rel_d    = ~mouse_btn & prev_btn_q;
                s1_center_d = center;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Stage 2: apply deltas with clamping/saturation and flag any visible change.
    always_comb begin
        sum_x = ACC_W'(cursor_x_q) + scale_delta(s1_dx_q);
        if (INVERT_Y != 0) begin
            sum_y = ACC_W'(cursor_y_q) - scale_delta(s1_dy_q);
        end else begin
            sum_y = ACC_W'(cursor_y_q) + scale_delta(s1_dy_q);
        end
        sum_w = {{(ACC_W-8){wheel_q[7]}}, wheel_q} + sext_delta(s1_dz_q);

        nx = s1_center_q ? CX_HOME : clamp_axis(sum_x, X_MAX);
        ny = s1_center_q ? CY_HOME : clamp_axis(sum_y, Y_MAX);
        if (sum_w < W_MIN) begin
            nw = 8'(W_MIN);
        end else if (sum_w > W_MAX) begin
            nw = 8'(W_MAX);
        end else begin
            nw = 8'(sum_w);
        end

        cursor_x_d    = cursor_x_q;
        cursor_y_d    = cursor_y_q;
        wheel_d       = wheel_q;
        btn_down_d    = btn_down_q;
        btn_press_d   = '0;
        btn_release_d = '0;
        update_d      = 1'b0;
        if (s1_valid_q) begin
            cursor_x_d    = nx;
            cursor_y_d    = ny;
            wheel_d       = nw;
            btn_down_d    = s1_btn_q;
            btn_press_d   = s1_press_q;
            btn_release_d = s1_rel_q;
            update_d      = (nx != cursor_x_q) || (ny != cursor_y_q) || (nw != wheel_q) ||
                            (|s1_press_q) || (|s1_rel_q) || s1_center_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_INIT;
            prev_x_q      <= '0;
            prev_y_q      <= '0;
            prev_z_q      <= '0;
            prev_btn_q    <= '0;
            s1_valid_q    <= 1'b0;
            s1_dx_q       <= '0;
            s1_dy_q       <= '0;
            s1_dz_q       <= '0;
            s1_btn_q      <= '0;
            s1_press_q    <= '0;
            s1_rel_q      <= '0;
            s1_center_q   <= 1'b0;
            cursor_x_q    <= CX_HOME;
            cursor_y_q    <= CY_HOME;
            wheel_q       <= '0;
            btn_down_q    <= '0;
            btn_press_q   <= '0;
            btn_release_q <= '0;
            update_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_x_q      <= prev_x_d;
            prev_y_q      <= prev_y_d;
            prev_z_q      <= prev_z_d;
            prev_btn_q    <= prev_btn_d;
            s1_valid_q    <= s1_valid_d;
            s1_dx_q       <= s1_dx_d;
            s1_dy_q       <= s1_dy_d;
            s1_dz_q       <= s1_dz_d;
            s1_btn_q      <= s1_btn_d;
            s1_press_q    <= s1_press_d;
            s1_rel_q      <= s1_rel_d;
            s1_center_q   <= s1_center_d;
            cursor_x_q    <= cursor_x_d;
            cursor_y_q    <= cursor_y_d;
            wheel_q       <= wheel_d;
            btn_down_q    <= btn_down_d;
            btn_press_q   <= btn_press_d;
            btn_release_q <= btn_release_d;
            update_q      <= update_d;
        end
    end

    assign cursor_x    = cursor_x_q;
    assign cursor_y    = cursor_y_q;
    assign wheel_pos   = wheel_q;
    assign btn_down    = btn_down_q;
    assign btn_press   = btn_press_q;
    assign btn_release = btn_release_q;
    assign update      = update_q;

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Bench for mouse_cursor_tracker: directed scenarios then random traffic against an integer reference model.
module tb_mouse_cursor_tracker;

    localparam int C_BITS = 11;
    localparam int SW     = 640;
    localparam int SH     = 480;
    localparam int INV_Y  = 1;
    localparam int THRESH = 8;
    localparam int MODN   = 1 << C_BITS;

    logic              clk = 1'b0;
    logic              reset;
    logic [C_BITS-1:0] mouse_x;
    logic [C_BITS-1:0] mouse_y;
    logic [C_BITS-1:0] mouse_z;
    logic [2:0]        mouse_btn;
    logic              center;
    logic [10:0]       cursor_x;
    logic [10:0]       cursor_y;
    logic [7:0]        wheel_pos;
    logic [2:0]        btn_down;
    logic [2:0]        btn_press;
    logic [2:0]        btn_release;
    logic              update;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: expected outputs plus one pending sample awaiting application.
    int m_cx, m_cy, m_wh, m_down, m_press, m_rel, m_upd;
    int m_track;
    int px, py, pz, pbtn;
    int p_v, p_dx, p_dy, p_dz, p_btn, p_press, p_rel, p_c;

    mouse_cursor_tracker #(
        .C_BITS      (C_BITS),
        .SCREEN_W    (SW),
        .SCREEN_H    (SH),
        .INVERT_Y    (INV_Y),
        .ACCEL_THRESH(THRESH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mouse_x    (mouse_x),
        .mouse_y    (mouse_y),
        .mouse_z    (mouse_z),
        .mouse_btn  (mouse_btn),
        .center     (center),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .wheel_pos  (wheel_pos),
        .btn_down   (btn_down),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .update     (update)
    );

    always #5 clk = ~clk;

    function automatic int sdelta(input int cur, input int prev);
        int d;
        d = (cur - prev) % MODN;
        if (d < 0) d += MODN;
        if (d >= MODN / 2) d -= MODN;
        return d;
    endfunction

    function automatic int accel(input int d);
`ifdef MOUSE_ACCEL_EN
        if (((d < 0) ? -d : d) >= THRESH) return 2 * d;
`endif
        return d;
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int nx, ny, nw, ty;
        if (reset === 1'b1) begin
            m_cx = SW / 2; m_cy = SH / 2; m_wh = 0;
            m_down = 0; m_press = 0; m_rel = 0; m_upd = 0;
            p_v = 0; m_track = 0;
            return;
        end
        if (p_v != 0) begin
            ty = (INV_Y != 0) ? m_cy - accel(p_dy) : m_cy + accel(p_dy);
            nx = (p_c != 0) ? SW / 2 : clampi(m_cx + accel(p_dx), 0, SW - 1);
            ny = (p_c != 0) ? SH / 2 : clampi(ty, 0, SH - 1);
            nw = clampi(m_wh + p_dz, -128, 127);
            m_upd = (nx != m_cx || ny != m_cy || nw != m_wh ||
                     p_press != 0 || p_rel != 0 || p_c != 0) ? 1 : 0;
            m_cx = nx; m_cy = ny; m_wh = nw;
            m_down = p_btn; m_press = p_press; m_rel = p_rel;
        end else begin
            m_press = 0; m_rel = 0; m_upd = 0;
        end
        if (m_track != 0) begin
            p_v     = 1;
            p_dx    = sdelta(int'(mouse_x), px);
            p_dy    = sdelta(int'(mouse_y), py);
            p_dz    = sdelta(int'(mouse_z), pz);
            p_btn   = int'(mouse_btn);
            p_press = int'(mouse_btn) & ~pbtn & 7;
            p_rel   = ~int'(mouse_btn) & pbtn & 7;
            p_c     = int'(center);
        end else begin
            p_v     = 0;
            m_track = 1;
        end
        px = int'(mouse_x); py = int'(mouse_y); pz = int'(mouse_z); pbtn = int'(mouse_btn);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("cursor_x", int'(cursor_x), m_cx);
        chk("cursor_y", int'(cursor_y), m_cy);
        chk("wheel_pos", int'($signed(wheel_pos)), m_wh);
        chk("btn_down", int'(btn_down), m_down);
        chk("btn_press", int'(btn_press), m_press);
        chk("btn_release", int'(btn_release), m_rel);
        chk("update", int'(update), m_upd);
    endtask

    initial begin
        int base;
        reset = 1'b1; mouse_x = 11'd100; mouse_y = '0; mouse_z = '0;
        mouse_btn = '0; center = 1'b0;
        m_track = 0; p_v = 0;
        px = 0; py = 0; pz = 0; pbtn = 0;
        p_dx = 0; p_dy = 0; p_dz = 0; p_btn = 0; p_press = 0; p_rel = 0; p_c = 0;
        repeat (3) tick();
        chk("rst_cursor_x", int'(cursor_x), 320);
        chk("rst_cursor_y", int'(cursor_y), 240);
        chk("rst_wheel", int'(wheel_pos), 0);

        reset = 1'b0;
        repeat (22) tick();
        chk("idle_cursor_x", int'(cursor_x), 320);

        mouse_x = 11'd105;
        repeat (2) tick();
        chk("step_x", int'(cursor_x), 325);
        chk("step_update", int'(update), 1);
        tick();
        chk("step_update_once", int'(update), 0);
`ifdef MOUSE_ACCEL_EN
        mouse_x = 11'd115;
        repeat (2) tick();
        chk("accel_x", int'(cursor_x), 345);
`endif

        mouse_x = 11'd2046;
        repeat (3) tick();
        base = m_cx;
        mouse_x = 11'd3;
        repeat (2) tick();
        chk("wrap_fwd", int'(cursor_x), base + 5);
        mouse_x = 11'd2046;
        repeat (2) tick();
        chk("wrap_back", int'(cursor_x), base);

        mouse_x = 11'(int'(mouse_x) - 400);
        repeat (3) tick();
        chk("clamp_lo", int'(cursor_x), 0);
        mouse_x = 11'(int'(mouse_x) - 10);
        repeat (2) tick();
        chk("clamp_hold", int'(cursor_x), 0);
        chk("clamp_no_update", int'(update), 0);

        mouse_y = 11'(int'(mouse_y) + 10);
        repeat (2) tick();
`ifdef MOUSE_ACCEL_EN
        chk("invert_y", int'(cursor_y), 220);
`else
        chk("invert_y", int'(cursor_y), 230);
`endif
        mouse_z = 11'(int'(mouse_z) + 200);
        repeat (2) tick();
        chk("wheel_sat_hi", int'($signed(wheel_pos)), 127);
        mouse_z = 11'(int'(mouse_z) - 300);
        repeat (2) tick();
        chk("wheel_sat_lo", int'($signed(wheel_pos)), -128);

        mouse_btn = 3'b001;
        repeat (2) tick();
        chk("press_left", int'(btn_press), 1);
        chk("down_left", int'(btn_down), 1);
        tick();
        chk("press_pulse", int'(btn_press), 0);
        mouse_btn = 3'b100;
        repeat (2) tick();
        chk("swap_release", int'(btn_release), 1);
        chk("swap_press", int'(btn_press), 4);
        chk("swap_update", int'(update), 1);
        tick();
        chk("swap_update_once", int'(update), 0);

        reset = 1'b1; mouse_x = 11'd500;
        repeat (2) tick();
        chk("midrst_x", int'(cursor_x), 320);
        chk("midrst_y", int'(cursor_y), 240);
        reset = 1'b0;
        repeat (6) tick();
        chk("rel_no_jump", int'(cursor_x), 320);
        mouse_x = 11'(int'(mouse_x) + 3);
        repeat (2) tick();
        center = 1'b1; mouse_x = 11'(int'(mouse_x) + 7);
        tick();
        center = 1'b0;
        tick();
        chk("center_x", int'(cursor_x), 320);
        chk("center_y", int'(cursor_y), 240);
        chk("center_update", int'(update), 1);

        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(99) == 0);
            if ($urandom_range(9) == 0) mouse_x = 11'($urandom);
            else mouse_x = 11'(int'(mouse_x) + int'($urandom_range(40)) - 20);
            if ($urandom_range(9) == 0) mouse_y = 11'($urandom);
            else mouse_y = 11'(int'(mouse_y) + int'($urandom_range(40)) - 20);
            mouse_z = 11'(int'(mouse_z) + int'($urandom_range(60)) - 30);
            if ($urandom_range(3) == 0) mouse_btn = 3'($urandom);
            center = ($urandom_range(19) == 0);
            tick();
        end
        reset = 1'b0; center = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mouse_cursor_tracker.md
Name: mouse_cursor_tracker

Overview:
Downstream consumer of the PS/2 mouse core's free-running counter outputs (x/y/z position counters, 3 buttons). Converts the wrapping counters into per-sample deltas and maintains a screen-clamped cursor position, a saturating wheel position, and button press/release event pulses. Feeds video overlay / UI logic on the same clock as the mouse core.

Parameters:
C_BITS, 11, width of incoming mouse_x/mouse_y/mouse_z counters
SCREEN_W, 640, horizontal extent; cursor_x range 0..SCREEN_W-1
SCREEN_H, 480, vertical extent; cursor_y range 0..SCREEN_H-1
INVERT_Y, 1, 1: positive mouse_y delta moves cursor up (cursor_y decreases); 0: down
ACCEL_THRESH, 8, |delta| at or above which acceleration applies (only with MOUSE_ACCEL_EN)

Ports:
clk  in  1  system clock; the only clock
reset  in  1  synchronous, active-high reset
mouse_x  in  C_BITS  wrapping X counter from mouse core
mouse_y  in  C_BITS  wrapping Y counter from mouse core
mouse_z  in  C_BITS  wrapping wheel counter from mouse core
mouse_btn  in  3  button levels {middle,right,left}, 1 = pressed
center  in  1  synchronous request to re-home cursor to screen centre
cursor_x  out  11  current cursor X
cursor_y  out  11  current cursor Y
wheel_pos  out  8  signed wheel position, saturating at -128/+127
btn_down  out  3  registered button levels
btn_press  out  3  one-cycle pulse per button on 0->1
btn_release  out  3  one-cycle pulse per button on 1->0
update  out  1  one-cycle pulse in the cycle any output above changed

Behaviour:
- One clock clk; reset is synchronous, active-high.
- Reset values: cursor_x=SCREEN_W/2, cursor_y=SCREEN_H/2 (320,240 at defaults), wheel_pos=0, btn_down=0, btn_press=0, btn_release=0, update=0; FSM to INIT.
- FSM states: INIT, TRACK.
  - INIT: one cycle; captures mouse_x/y/z/btn into prev registers as baseline; no deltas, no events, update=0; -> TRACK.
  - TRACK: every cycle, stage 1 registers dx=cur-prev, dy, dz (mod 2^C_BITS, interpreted as signed C_BITS, range -2^(C_BITS-1)..2^(C_BITS-1)-1), button XOR/levels, center; prev <= cur.
  - Stage 2 applies stage-1 results to outputs. Latency: input change at edge N -> outputs and update valid after edge N+2.
- Wrap-around: counter 2046->3 (C_BITS=11) is dx=+5; 3->2046 is dx=-5.
- Arithmetic: signed accumulation at C_BITS+2 bits; result clamped to [0,SCREEN_W-1] / [0,SCREEN_H-1]; never wraps.
- Y direction: INVERT_Y=1 -> cursor_y - dy; INVERT_Y=0 -> cursor_y + dy.
- Wheel: wheel_pos + dz, saturated to [-128,+127].
- Buttons: btn_press = cur & ~prev, btn_release = ~cur & prev, pulses exactly one cycle; btn_down follows mouse_btn with 2-cycle latency.
- center: has priority over a same-cycle dx/dy; cursor set to centre, wheel unaffected, button events still processed; update=1.
- update=1 iff any cursor/wheel output value changed, any btn_press/btn_release bit is set, or center applied. Clamped-at-edge motion producing no change -> update=0.
- Simultaneous x/y/z/button changes -> single update pulse, all applied in the same cycle.
- Reset mid-operation: in-flight stage-1 data discarded; outputs to reset values next edge; INIT re-captures baseline, so counter values present at reset release produce no jump.

Optional Feature:
MOUSE_ACCEL_EN: when defined, any dx or dy with |delta| >= ACCEL_THRESH is doubled before clamping (sign preserved); wheel unaffected. When undefined, deltas applied 1:1 and ACCEL_THRESH is unused.

Test Plan:
- Reset, mouse_x=100 held -> after INIT cursor=(320,240), wheel_pos=0, no update pulses for 20 cycles.
- mouse_x 100->105 -> cursor_x=325 two cycles later, update high exactly one cycle; with MOUSE_ACCEL_EN (thresh 8) 100->110 -> cursor_x=340.
- mouse_x 2046->3 -> cursor_x +5; then 3->2046 -> back; mouse_x step -400 from cursor_x 325 -> cursor_x=0, further -10 -> cursor_x=0, update=0.
- INVERT_Y=1, mouse_y +10 -> cursor_y=230; mouse_z +200 -> wheel_pos=127; mouse_z -300 -> wheel_pos=-128.
- mouse_btn 000->001 -> btn_press=001 one cycle, btn_down=001; 001->100 same cycle -> btn_release=001 and btn_press=100 together, single update.
- Assert reset while cursor=(10,10), mouse_x=500 -> cursor=(320,240); release with mouse_x=500 held -> no motion; center pulse with simultaneous dx=+7 -> cursor=(320,240).
